// File: rtl/buzzer_score_ctrl.sv
// Quiz buzzer controller: three team buttons race for the lock, the host
// judges the winner's answer, and a two-digit BCD score per team is kept
// and shown for the team that last held the lock.
module buzzer_score_ctrl #(
  parameter int ANSWER_TIMEOUT = 500_000_000,
  parameter int MAX_SCORE      = 99
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [2:0] buzz,
  input  logic       btn_correct,
  input  logic       btn_wrong,
  input  logic       btn_clear,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [2:0] thousands,
  output logic       locked
);

  localparam int              CNT_W     = (ANSWER_TIMEOUT > 1) ? $clog2(ANSWER_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANSWER_TIMEOUT - 1);
  localparam logic [7:0]      SCORE_MAX = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

  typedef enum logic [1:0] {ARMED, LOCKED, HOLD} state_t;

  state_t state, state_nxt;

  // Input bundle: {buzz A, buzz B, buzz C, correct, wrong, clear}
  logic [5:0] raw, in_p0, in_p1, in_p2, rise;
  logic [2:0] buzz_lvl, buzz_rise, winner;
  logic       correct_rise, wrong_rise, clear_rise;

  // Per-team BCD score {tens, ones}; index matches the thousands bit
  logic [2:0][7:0] score;
  logic [7:0]      disp;
  logic [CNT_W-1:0] cnt;

  logic do_lock, do_inc, do_dec, cnt_inc;

  // BCD increment that stops at the configured ceiling
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == SCORE_MAX)      return s;
    else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    else                     return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // BCD decrement that stops at zero
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    if (s == 8'h00)          return s;
    else if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
    else                     return {s[7:4], s[3:0] - 4'd1};
  endfunction

  assign raw = {buzz, btn_correct, btn_wrong, btn_clear};

  // Two-flop synchronizer followed by a delay flop for edge detection
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      in_p0 <= '0;
      in_p1 <= '0;
      in_p2 <= '0;
    end else begin
      in_p0 <= raw;
      in_p1 <= in_p0;
      in_p2 <= in_p1;
    end
  end

  assign rise         = in_p1 & ~in_p2;
  assign buzz_lvl     = in_p1[5:3];
  assign buzz_rise    = rise[5:3];
  assign correct_rise = rise[2];
  assign wrong_rise   = rise[1];
  assign clear_rise   = rise[0];

  // Fixed priority A > B > C among simultaneous presses
  assign winner = buzz_rise[2] ? 3'b100 : (buzz_rise[1] ? 3'b010 : 3'b001);

  // FSM state register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= ARMED;
    else       state <= state_nxt;
  end

  // FSM next state and datapath strobes; clear overrides everything
  always_comb begin
    state_nxt = state;
    do_lock   = 1'b0;
    do_inc    = 1'b0;
    do_dec    = 1'b0;
    cnt_inc   = 1'b0;
    if (clear_rise) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (|buzz_rise) begin
            do_lock   = 1'b1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (correct_rise) begin
            do_inc    = 1'b1;
            state_nxt = HOLD;
          end else if (wrong_rise) begin
            do_dec    = 1'b1;
            state_nxt = HOLD;
          end else if (cnt == CNT_LAST) begin
            state_nxt = ARMED;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        HOLD: begin
          if (buzz_lvl == 3'b000) state_nxt = ARMED;
        end
        default: state_nxt = ARMED;
      endcase
    end
  end

  // Answer timeout counter, restarted on every lock
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (do_lock) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + CNT_W'(1);
  end

  // Score bank: judgement applies only to the team shown in thousands
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      score <= '0;
    end else if (clear_rise) begin
      score <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (thousands[i] && do_inc)      score[i] <= bcd_inc(score[i]);
        else if (thousands[i] && do_dec) score[i] <= bcd_dec(score[i]);
      end
    end
  end

  assign disp = thousands[2] ? score[2] : (thousands[1] ? score[1] : score[0]);

  // Registered display and lock indicator
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      thousands <= 3'b100;
      locked    <= 1'b0;
      ones      <= 4'd0;
      tens      <= 4'd0;
    end else begin
      if (clear_rise)   thousands <= 3'b100;
      else if (do_lock) thousands <= winner;
      locked <= (state_nxt == LOCKED);
      ones   <= disp[3:0];
      tens   <= disp[7:4];
    end
  end

endmodule
